// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - LC-3b pipeline stall/bubble/flush and indirect-phase controller
module hazard_control_unit #(
    parameter int REG_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic              ex_load_regfile,
    input  logic              ex_mem_read,
    input  logic              mem_indirect,
    input  logic              mem_access,
    input  logic              mem_branch_taken,
    input  logic              imem_read,
    input  logic              imem_resp,
    input  logic              dmem_resp,
    input  logic              wb_load_regfile,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_fetch,
    output logic              stall_id_ex,
    output logic              stall_ex_mem,
    output logic              stall_mem_wb,
    output logic              bubble_ex,
    output logic              bubble_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              indirect_sel,
    output logic              save_valid,
    output logic [REG_W-1:0]  save_dest,
    output logic [DATA_W-1:0] save_data
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_IND = 1'b1
    } state_t;

    state_t state, state_next;

    logic fetch_wait;
    logic eff_mem_access;
    logic mem_wait;
    logic to_ind;
    logic to_run;
    logic ind_hold;
    logic load_use;

    // The second LDI/STI access is implied by the IND state, so it waits on dmem
    // even though MEM's own mem_access flag may describe only the first access.
    assign fetch_wait     = imem_read & ~imem_resp;
    assign eff_mem_access = mem_access | (state == ST_IND);
    assign mem_wait       = fetch_wait | (eff_mem_access & ~dmem_resp);

    assign to_ind   = (state == ST_RUN) & mem_indirect & dmem_resp & ~fetch_wait;
    assign to_run   = (state == ST_IND) & dmem_resp & ~fetch_wait;
    assign ind_hold = to_ind | ((state == ST_IND) & ~to_run);

    assign load_use = ex_mem_read & ex_load_regfile &
                      ((id_src1_used & (ex_dest == id_src1)) |
                       (id_src2_used & (ex_dest == id_src2)));

    assign indirect_sel = (state == ST_IND);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        stall_fetch  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        bubble_ex    = 1'b0;
        bubble_wb    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;

        if (to_ind) begin
            state_next = ST_IND;
        end else if (to_run) begin
            state_next = ST_RUN;
        end

        if (mem_wait) begin
            stall_fetch  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
        end else if (ind_hold) begin
            // MEM/WB advances with a bubble so the LDI does not retire twice.
            stall_fetch  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            bubble_wb    = 1'b1;
        end else if (mem_branch_taken) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
        end else if (load_use) begin
            stall_fetch  = 1'b1;
            bubble_ex    = 1'b1;
        end
    end

    // Holds a writeback that retired while EX was frozen, for the forwarding unit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            save_valid <= 1'b0;
            save_dest  <= '0;
            save_data  <= '0;
        end else if (wb_load_regfile && stall_ex_mem) begin
            save_valid <= 1'b1;
            save_dest  <= wb_dest;
            save_data  <= wb_data;
        end else if (!stall_ex_mem) begin
            save_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  id_src1, id_src2, ex_dest, wb_dest;
    logic        id_src1_used, id_src2_used, ex_load_regfile, ex_mem_read;
    logic        mem_indirect, mem_access, mem_branch_taken;
    logic        imem_read, imem_resp, dmem_resp, wb_load_regfile;
    logic [15:0] wb_data;
    logic        stall_fetch, stall_id_ex, stall_ex_mem, stall_mem_wb;
    logic        bubble_ex, bubble_wb, flush_if_id, flush_id_ex, indirect_sel;
    logic        save_valid;
    logic [2:0]  save_dest;
    logic [15:0] save_data;

    int n_cmp = 0;
    int n_err = 0;

    // {stall_fetch, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_ex, bubble_wb, flush_if_id, flush_id_ex, indirect_sel}
    logic [8:0] outs;
    assign outs = {stall_fetch, stall_id_ex, stall_ex_mem, stall_mem_wb,
                   bubble_ex, bubble_wb, flush_if_id, flush_id_ex, indirect_sel};

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_W(3), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
        .ex_dest(ex_dest), .ex_load_regfile(ex_load_regfile), .ex_mem_read(ex_mem_read),
        .mem_indirect(mem_indirect), .mem_access(mem_access), .mem_branch_taken(mem_branch_taken),
        .imem_read(imem_read), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
        .wb_load_regfile(wb_load_regfile), .wb_dest(wb_dest), .wb_data(wb_data),
        .stall_fetch(stall_fetch), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
        .bubble_ex(bubble_ex), .bubble_wb(bubble_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .indirect_sel(indirect_sel),
        .save_valid(save_valid), .save_dest(save_dest), .save_data(save_data)
    );

    task automatic idle();
        id_src1 = 3'd0; id_src2 = 3'd0; id_src1_used = 1'b0; id_src2_used = 1'b0;
        ex_dest = 3'd0; ex_load_regfile = 1'b0; ex_mem_read = 1'b0;
        mem_indirect = 1'b0; mem_access = 1'b0; mem_branch_taken = 1'b0;
        imem_read = 1'b0; imem_resp = 1'b0; dmem_resp = 1'b0;
        wb_load_regfile = 1'b0; wb_dest = 3'd0; wb_data = 16'h0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 9'b0_0000_0000) begin
            n_err++;
            $display("FAIL reset_outs: got %b want %b", outs, 9'b0);
        end
        n_cmp++;
        if ({save_valid, save_dest, save_data} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_save: got %b/%0d/%h want 0/0/0000", save_valid, save_dest, save_data);
        end
    endtask

    task automatic test_load_use();
        step();
        idle();
        ex_mem_read = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd3;
        id_src1 = 3'd3; id_src1_used = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 9'b1000_1000_0) begin
            n_err++;
            $display("FAIL load_use_src1: got %b want %b", outs, 9'b100010000);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (outs !== 9'b0) begin
            n_err++;
            $display("FAIL load_use_release: got %b want %b", outs, 9'b0);
        end
        ex_mem_read = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd3;
        id_src1 = 3'd3; id_src1_used = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 9'b0) begin
            n_err++;
            $display("FAIL load_use_unused: got %b want %b", outs, 9'b0);
        end
        id_src2 = 3'd3; id_src2_used = 1'b1; id_src1 = 3'd1;
        #1;
        n_cmp++;
        if (outs !== 9'b1000_1000_0) begin
            n_err++;
            $display("FAIL load_use_src2: got %b want %b", outs, 9'b100010000);
        end
        ex_dest = 3'd4;
        #1;
        n_cmp++;
        if (outs !== 9'b0) begin
            n_err++;
            $display("FAIL load_use_nomatch: got %b want %b", outs, 9'b0);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        step();
        idle();
        mem_access = 1'b1; dmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (outs !== 9'b1111_0000_0) begin
                n_err++;
                $display("FAIL mem_wait_cyc%0d: got %b want %b", i, outs, 9'b111100000);
            end
            step();
        end
        dmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 9'b0) begin
            n_err++;
            $display("FAIL mem_wait_done: got %b want %b", outs, 9'b0);
        end
        dmem_resp = 1'b0; mem_access = 1'b0;
        imem_read = 1'b1; imem_resp = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 9'b1111_0000_0) begin
            n_err++;
            $display("FAIL fetch_wait: got %b want %b", outs, 9'b111100000);
        end
        idle();
    endtask

    task automatic test_ldi();
        step();
        idle();
        mem_indirect = 1'b1; mem_access = 1'b1; dmem_resp = 1'b1;
        imem_read = 1'b1; imem_resp = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 9'b1111_0000_0) begin
            n_err++;
            $display("FAIL ldi_fetch_block: got %b want %b", outs, 9'b111100000);
        end
        step();
        imem_read = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 9'b1110_0100_0) begin
            n_err++;
            $display("FAIL ldi_first_resp: got %b want %b", outs, 9'b111001000);
        end
        step();
        dmem_resp = 1'b0;
        wb_load_regfile = 1'b1; wb_dest = 3'd5; wb_data = 16'h1234;
        #1;
        n_cmp++;
        if (outs !== 9'b1111_0000_1) begin
            n_err++;
            $display("FAIL ldi_ind_wait: got %b want %b", outs, 9'b111100001);
        end
        step();
        wb_load_regfile = 1'b0; wb_dest = 3'd0; wb_data = 16'h0000;
        #1;
        n_cmp++;
        if ({save_valid, save_dest, save_data} !== {1'b1, 3'd5, 16'h1234}) begin
            n_err++;
            $display("FAIL save_capture: got %b/%0d/%h want 1/5/1234", save_valid, save_dest, save_data);
        end
        dmem_resp = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 9'b0000_0000_1) begin
            n_err++;
            $display("FAIL ldi_second_resp: got %b want %b", outs, 9'b000000001);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (indirect_sel !== 1'b0) begin
            n_err++;
            $display("FAIL ldi_exit: got %b want 0", indirect_sel);
        end
        n_cmp++;
        if ({save_valid, save_data} !== {1'b0, 16'h1234}) begin
            n_err++;
            $display("FAIL save_clear: got %b/%h want 0/1234", save_valid, save_data);
        end
    endtask

    task automatic test_priority();
        step();
        idle();
        mem_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd2;
        id_src1 = 3'd2; id_src1_used = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 9'b0000_0011_0) begin
            n_err++;
            $display("FAIL branch_over_load_use: got %b want %b", outs, 9'b000000110);
        end
        mem_access = 1'b1; dmem_resp = 1'b0;
        #1;
        n_cmp++;
        if (outs !== 9'b1111_0000_0) begin
            n_err++;
            $display("FAIL wait_over_branch: got %b want %b", outs, 9'b111100000);
        end
        idle();
    endtask

    task automatic test_reset_mid_ind();
        step();
        idle();
        mem_indirect = 1'b1; mem_access = 1'b1; dmem_resp = 1'b1;
        wb_load_regfile = 1'b1; wb_dest = 3'd6; wb_data = 16'hBEEF;
        step();
        idle();
        mem_indirect = 1'b1; mem_access = 1'b1;
        #1;
        n_cmp++;
        if ({indirect_sel, save_valid, save_dest, save_data} !== {1'b1, 1'b1, 3'd6, 16'hBEEF}) begin
            n_err++;
            $display("FAIL ind_save_setup: got %b/%b/%0d/%h want 1/1/6/beef",
                     indirect_sel, save_valid, save_dest, save_data);
        end
        rst_n = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (outs !== 9'b0) begin
            n_err++;
            $display("FAIL reset_mid_ind_outs: got %b want %b", outs, 9'b0);
        end
        n_cmp++;
        if (save_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_ind_save: got %b want 0", save_valid);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_ldi();
        test_priority();
        test_reset_mid_ind();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard and stall controller for the LC-3b five-stage pipeline.
- Generates the state the forwarding unit consumes: the indirect-phase select and the saved-writeback bundle (save_valid/save_dest/save_data). It also generates every stall, bubble and flush signal.
- Sequences the two data-memory accesses of LDI/STI, holds the pipeline on outstanding memory responses, inserts load-use bubbles and flushes on taken branches.

Parameters:
- REG_W, 3, register-specifier width
- DATA_W, 16, datapath width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- id_src1  in  REG_W  ID-stage SR1
- id_src2  in  REG_W  ID-stage SR2
- id_src1_used  in  1  ID instruction reads SR1
- id_src2_used  in  1  ID instruction reads SR2
- ex_dest  in  REG_W  EX-stage destination
- ex_load_regfile  in  1  EX instruction writes regfile
- ex_mem_read  in  1  EX instruction is LDR/LDB/LDI
- mem_indirect  in  1  MEM instruction is LDI/STI
- mem_access  in  1  MEM instruction accesses dmem
- mem_branch_taken  in  1  taken branch/jump resolved in MEM
- imem_read  in  1  fetch request outstanding
- imem_resp  in  1  fetch complete
- dmem_resp  in  1  data access complete
- wb_load_regfile  in  1  WB instruction writes regfile
- wb_dest  in  REG_W  WB destination
- wb_data  in  DATA_W  WB write value
- stall_fetch  out  1  hold PC and IF/ID
- stall_id_ex  out  1  hold ID/EX
- stall_ex_mem  out  1  hold EX/MEM
- stall_mem_wb  out  1  hold MEM/WB
- bubble_ex  out  1  load NOP into ID/EX
- bubble_wb  out  1  load NOP into MEM/WB
- flush_if_id  out  1  squash IF/ID
- flush_id_ex  out  1  squash ID/EX
- indirect_sel  out  1  second (indirect) dmem phase active
- save_valid  out  1  saved writeback valid
- save_dest  out  REG_W  saved destination
- save_data  out  DATA_W  saved value

Behaviour:
- Reset (rst_n=0 at posedge clk): state=RUN, save_valid=0, save_dest=0, save_data=0. All outputs are 0 while inputs are idle.
- mem_wait = (imem_read & ~imem_resp) | (mem_access & ~dmem_resp).
- States: RUN, IND.
  - RUN→IND when mem_indirect & dmem_resp & ~(imem_read & ~imem_resp). This is the first access done and fetch not pending.
  - IND→RUN when dmem_resp & ~(imem_read & ~imem_resp).
  - In IND, mem_access is treated as 1.
- indirect_sel = (state==IND).
- Priority, highest first: mem_wait > indirect hold > branch flush > load-use.
- mem_wait: all four stall_* = 1. bubble_ex=0, bubble_wb=0, flush_*=0. No state change unless the transition condition above holds.
- Indirect hold applies in RUN when the transition fires, and in IND while waiting.
  - stall_fetch, stall_id_ex and stall_ex_mem are 1.
  - bubble_wb=1, so no duplicate WB occurs.
  - stall_mem_wb=0.
- Branch flush (mem_branch_taken, no higher-priority event): flush_if_id=1 and flush_id_ex=1 for exactly one cycle. A load-use hazard in the same cycle is suppressed.
- Load-use applies when ex_mem_read & ex_load_regfile & ((id_src1_used & ex_dest==id_src1) | (id_src2_used & ex_dest==id_src2)).
  - Outputs: stall_fetch=1, bubble_ex=1, stall_id_ex=0.
  - Lasts exactly one cycle; the next cycle sees the bubble in EX.
- Save register:
  - At posedge, if wb_load_regfile & stall_ex_mem (WB retires while EX is held), capture save_dest←wb_dest and save_data←wb_data, and set save_valid←1.
  - Otherwise, on any cycle with stall_ex_mem=0, clear save_valid←0; save_dest/save_data hold.
  - Capture has priority when both conditions could apply.
- Reset mid-IND returns the block to RUN and clears save_valid in the same edge.
- All control outputs are combinational from state and inputs. The only registers are state and the save register.

Test Plan:
- Load-use: ex_mem_read=1, ex_load_regfile=1, ex_dest=3, id_src1=3, id_src1_used=1 -> stall_fetch=1, bubble_ex=1 for one cycle. With id_src1_used=0 there is no stall.
- Mem wait: mem_access=1, dmem_resp=0 for 3 cycles, then 1 -> all stall_*=1 for 3 cycles, none on the 4th. No bubbles during the wait.
- LDI sequence: mem_indirect=1, first dmem_resp -> state IND, indirect_sel=1 next cycle, bubble_wb=1. Second dmem_resp -> indirect_sel=0 the following cycle.
- Save capture: during IND with wb_load_regfile=1, wb_dest=5, wb_data=0x1234 -> save_valid=1, save_dest=5, save_data=0x1234. Cleared on the first unstalled cycle.
- Priority: mem_branch_taken=1 together with a load-use hazard -> flush_if_id=1, flush_id_ex=1, bubble_ex=0. Adding dmem wait -> stalls only, no flush.
- Reset: rst_n=0 while in IND with save_valid=1 -> next cycle indirect_sel=0, save_valid=0, all outputs 0.
